ahb_arbiter: RTL and testbench



---
 rtl/ahb_pkg.sv | 43 ++++
 rtl/ahb_arb_pick.sv | 31 +++
 rtl/ahb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ahb_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/burst codes, arbiter state encoding and
// the burst-length decode also used by the memory slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'b00,
    ARB_ARB      = 2'b01,
    ARB_OWN      = 2'b10,
    ARB_HANDOVER = 2'b11
  } arb_state_e;

  localparam int BEAT_CNT_W = 5;

  // Zero means unbounded (INCR): the length is not known up front.
  function automatic logic [BEAT_CNT_W-1:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE:                return 5'd1;
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational picker: first requester found scanning upward from ptr+1,
// wrapping modulo NUM_MASTERS. ptr = NUM_MASTERS-1 gives lowest-index priority.
module ahb_arb_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int MW          = 3
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] win_oh,
  output logic [MW-1:0]          win_idx,
  output logic                   win_vld
);

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    // Offset o walks the ring; candidate i matches ptr+o with or without wrap.
    for (int o = 1; o <= NUM_MASTERS; o++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!win_vld && req[i] &&
            ((int'(ptr) + o == i) || (int'(ptr) + o == i + NUM_MASTERS))) begin
          win_vld    = 1'b1;
          win_idx    = MW'(i);
          win_oh[i]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Burst-aware AHB-Lite arbiter: holds a grant for a whole defined-length burst or
// locked sequence. Define AHB_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int MW             = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock,
  output logic [1:0]             arb_state
);

  localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

  arb_state_e              state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [MW-1:0]           gidx_q, gidx_d;
  logic [MW-1:0]           master_q, master_d;
  logic                    mastlock_q, mastlock_d;
  logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    fresh_q, fresh_d;

  logic [NUM_MASTERS-1:0]  pick_oh;
  logic [MW-1:0]           pick_idx;
  logic                    pick_vld;
  logic [MW-1:0]           pick_ptr;
  logic [BEAT_CNT_W-1:0]   beats;
  logic                    own_req, own_lock, burst_end;

  ahb_arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .MW          (MW)
  ) u_pick (
    .req     (hbusreq),
    .ptr     (pick_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

`ifdef AHB_ARB_FIXED_PRIO_EN
  assign pick_ptr = MW'(NUM_MASTERS - 1);
`else
  logic [MW-1:0] rr_q, rr_d;

  assign pick_ptr = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (hready && (state_q == ARB_ARB || state_q == ARB_HANDOVER) && pick_vld)
      rr_d = pick_idx;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) rr_q <= DEF_IDX;
    else          rr_q <= rr_d;
  end
`endif

  // Grant is one-hot, so masking avoids a variable-width index.
  assign own_req  = |(hbusreq & grant_q);
  assign own_lock = |(hlock & grant_q);
  assign beats    = burst_beats(hburst);

  always_comb begin
    cnt_d = cnt_q;
    if (hready) begin
      if (htrans == HTRANS_NONSEQ)
        cnt_d = (beats == '0) ? '0 : beats - 5'd1;
      else if (htrans == HTRANS_SEQ && cnt_q != '0)
        cnt_d = cnt_q - 5'd1;
    end
  end

  // A nonzero count marks a defined-length burst in flight; request drops and BUSY are ignored.
  always_comb begin
    burst_end = 1'b0;
    if (htrans == HTRANS_NONSEQ)
      burst_end = (hburst == HBURST_SINGLE);
    else if (cnt_q != '0)
      burst_end = (htrans == HTRANS_SEQ) && (cnt_q == 5'd1);
    else
      burst_end = (htrans == HTRANS_IDLE) || (!own_req && htrans != HTRANS_BUSY);
  end

  // fresh_q masks the first OWN cycle: the new owner has not driven an address yet.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    fresh_d = fresh_q;
    if (hready) begin
      case (state_q)
        ARB_IDLE: if (|hbusreq) state_d = ARB_ARB;
        ARB_ARB, ARB_HANDOVER: begin
          if (pick_vld) begin
            grant_d = pick_oh;
            gidx_d  = pick_idx;
            fresh_d = 1'b1;
            state_d = ARB_OWN;
          end else begin
            grant_d = DEF_OH;
            gidx_d  = DEF_IDX;
            state_d = ARB_IDLE;
          end
        end
        ARB_OWN: begin
          fresh_d = 1'b0;
          if (!fresh_q && burst_end && !own_lock) state_d = ARB_HANDOVER;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // hmaster and hmastlock trail the grant by one accepted address phase.
  always_comb begin
    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (hready) begin
      master_d   = gidx_q;
      mastlock_d = own_lock;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ARB_IDLE;
      grant_q    <= DEF_OH;
      gidx_q     <= DEF_IDX;
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
      cnt_q      <= '0;
      fresh_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      cnt_q      <= cnt_d;
      fresh_q    <= fresh_d;
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = master_q;
  assign hmastlock = mastlock_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with two masters; expected grant/master/state
// sequences are written out per scenario.
module tb_ahb_arbiter;
  import ahb_pkg::*;

`ifdef AHB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       hclk, hresetn, hready, hmastlock;
  logic [1:0] hbusreq, hlock, htrans, hgrant, arb_state;
  logic [2:0] hburst, hmaster;
  int         n_chk = 0;
  int         n_err = 0;
  int         exp_m;

  ahb_arbiter #(
    .NUM_MASTERS    (2),
    .MW             (3),
    .DEFAULT_MASTER (0)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock),
    .arb_state (arb_state)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic go_idle(input string tag);
    hbusreq = 2'b00;
    hlock   = 2'b00;
    htrans  = HTRANS_IDLE;
    hready  = 1'b1;
    repeat (6) cyc();
    check({tag, "_idle_state"}, 32'(arb_state), 0);
    check({tag, "_idle_grant"}, 32'(hgrant), 1);
    check({tag, "_idle_master"}, 32'(hmaster), 0);
  endtask

  initial begin
    hresetn = 1'b0;
    hbusreq = 2'b00;
    hlock   = 2'b00;
    htrans  = HTRANS_IDLE;
    hburst  = HBURST_SINGLE;
    hready  = 1'b1;
    repeat (2) cyc();
    hresetn = 1'b1;
    cyc();
    check("rst_grant", 32'(hgrant), 1);
    check("rst_master", 32'(hmaster), 0);
    check("rst_lock", 32'(hmastlock), 0);
    check("rst_state", 32'(arb_state), 0);

    // M1 alone, one SINGLE transfer
    hbusreq = 2'b10;
    cyc();
    check("single_arb_state", 32'(arb_state), 1);
    check("single_arb_grant", 32'(hgrant), 1);
    cyc();
    check("single_grant", 32'(hgrant), 2);
    check("single_master_lag", 32'(hmaster), 0);
    check("single_own", 32'(arb_state), 2);
    cyc();
    check("single_master", 32'(hmaster), 1);
    htrans  = HTRANS_NONSEQ;
    hbusreq = 2'b00;
    cyc();
    check("single_handover", 32'(arb_state), 3);
    check("single_grant_hold", 32'(hgrant), 2);
    htrans = HTRANS_IDLE;
    cyc();
    check("single_def_grant", 32'(hgrant), 1);
    check("single_def_state", 32'(arb_state), 0);
    check("single_master_hold", 32'(hmaster), 1);
    cyc();
    check("single_def_master", 32'(hmaster), 0);

    // M0 INCR4; M1 requests at beat 2, M0 drops its request mid-burst
    hbusreq = 2'b01;
    hburst  = HBURST_INCR4;
    cyc();
    check("incr4_arb", 32'(arb_state), 1);
    cyc();
    check("incr4_grant", 32'(hgrant), 1);
    cyc();
    for (int b = 0; b < 4; b++) begin
      htrans  = (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      hbusreq = (b == 0) ? 2'b01 : ((b == 1) ? 2'b11 : 2'b10);
      cyc();
      check($sformatf("incr4_beat%0d_grant", b), 32'(hgrant), 1);
      check($sformatf("incr4_beat%0d_state", b), 32'(arb_state), (b == 3) ? 3 : 2);
    end
    htrans = HTRANS_IDLE;
    cyc();
    check("incr4_switch_grant", 32'(hgrant), 2);
    check("incr4_switch_master", 32'(hmaster), 0);
    cyc();
    check("incr4_new_master", 32'(hmaster), 1);
    go_idle("incr4");

    // Both masters request SINGLEs back to back
    hbusreq = 2'b11;
    hburst  = HBURST_SINGLE;
    cyc();
    check("alt_arb", 32'(arb_state), 1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      exp_m = FIXED ? 0 : (k % 2);
      check($sformatf("alt_grant%0d", k), 32'(hgrant), 32'(1 << exp_m));
      cyc();
      check($sformatf("alt_master%0d", k), 32'(hmaster), 32'(exp_m));
      htrans = HTRANS_NONSEQ;
      cyc();
      check($sformatf("alt_handover%0d", k), 32'(arb_state), 3);
      htrans = HTRANS_IDLE;
      cyc();
    end
    go_idle("alt");

    // M1 locked across two INCR4 bursts while M0 requests
    hbusreq = 2'b10;
    hlock   = 2'b10;
    hburst  = HBURST_INCR4;
    cyc();
    cyc();
    check("lock_grant", 32'(hgrant), 2);
    hbusreq = 2'b11;
    cyc();
    check("lock_master", 32'(hmaster), 1);
    check("lock_mastlock", 32'(hmastlock), 1);
    for (int i = 0; i < 8; i++) begin
      htrans = (i % 4 == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      hlock  = (i == 7) ? 2'b00 : 2'b10;
      cyc();
      check($sformatf("lock_beat%0d_grant", i), 32'(hgrant), 2);
      check($sformatf("lock_beat%0d_state", i), 32'(arb_state), (i == 7) ? 3 : 2);
      check($sformatf("lock_beat%0d_mastlock", i), 32'(hmastlock), (i == 7) ? 0 : 1);
    end
    htrans  = HTRANS_IDLE;
    hbusreq = 2'b01;
    cyc();
    check("unlock_grant", 32'(hgrant), 1);
    cyc();
    check("unlock_master", 32'(hmaster), 0);
    check("unlock_mastlock", 32'(hmastlock), 0);
    go_idle("lock");

    // M0 WRAP8 with a 3-cycle wait state after beat 3, then reset mid-burst
    hbusreq = 2'b01;
    hburst  = HBURST_WRAP8;
    cyc();
    cyc();
    cyc();
    htrans = HTRANS_NONSEQ;
    cyc();
    htrans = HTRANS_SEQ;
    cyc();
    cyc();
    hready  = 1'b0;
    hbusreq = 2'b11;
    for (int s = 0; s < 3; s++) begin
      cyc();
      check($sformatf("stall%0d_grant", s), 32'(hgrant), 1);
      check($sformatf("stall%0d_master", s), 32'(hmaster), 0);
      check($sformatf("stall%0d_state", s), 32'(arb_state), 2);
    end
    hready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      hbusreq = (j >= 2) ? 2'b10 : 2'b11;
      cyc();
      check($sformatf("wrap8_seq%0d_state", j), 32'(arb_state), (j == 4) ? 3 : 2);
    end
    htrans = HTRANS_IDLE;
    cyc();
    check("wrap8_next_grant", 32'(hgrant), 2);
    cyc();
    check("wrap8_next_master", 32'(hmaster), 1);
    htrans = HTRANS_NONSEQ;
    hburst = HBURST_INCR8;
    cyc();
    check("midburst_state", 32'(arb_state), 2);
    #2 hresetn = 1'b0;
    #1;
    check("arst_grant", 32'(hgrant), 1);
    check("arst_master", 32'(hmaster), 0);
    check("arst_lock", 32'(hmastlock), 0);
    check("arst_state", 32'(arb_state), 0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    hbusreq = 2'b11;
    htrans  = HTRANS_IDLE;
    cyc();
    check("post_rst_arb", 32'(arb_state), 1);
    cyc();
    check("post_rst_grant", 32'(hgrant), FIXED ? 1 : 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
